prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameter PC_SIZE, default 10: width of the instruction-memory address (PC_write).
REQ-002 Parameter ADDR_STEP, default 4: address increment per loaded instruction word.
REQ-003 Parameter CLEAR_CYCLES, default 2: cycles mem_reset is held in CLEAR.
REQ-004 clock  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: asynchronous, active-high; forces the reset state immediately.
REQ-006 load_valid  in  1: load_word/load_last are valid this cycle.
REQ-007 load_ready  out  1: controller accepts a word this cycle.
REQ-008 load_word  in  32: instruction to store.
REQ-009 load_last  in  1: marks the final word of the program.
REQ-010 start  in  1: one-cycle pulse; begins a load, or begins execution from ARMED.
REQ-011 halt_req  in  1: stops execution.
REQ-012 max_cycles  in  16: run-cycle limit (used only under REQ-030).
REQ-013 core_reset  out  1: reset to the pipeline core.
REQ-014 mem_reset  out  1: drives the instruction-memory clear input.
REQ-015 rw  out  1: 1 = instruction-memory write, 0 = fetch.
REQ-016 PC_write  out  PC_SIZE: instruction-memory write address.
REQ-017 instruction_in  out  32: instruction-memory write data.
REQ-018 busy  out  1, done  out  1, overflow  out  1, run_count  out  16: status.

Function
REQ-019 FSM states IDLE, CLEAR, LOAD, ARMED, RUN, DONE; all outputs registered.
- IDLE: start -> CLEAR.
- CLEAR: mem_reset=1 for exactly CLEAR_CYCLES cycles -> LOAD.
- LOAD: load_last accepted -> ARMED.
- ARMED: start -> RUN.
- RUN: halt_req or limit -> DONE.
- DONE: start -> CLEAR.
REQ-020 core_reset is 1 in every state except RUN; deassertion takes effect on the first RUN cycle.
REQ-021 LOAD: load_ready=1; a transfer occurs when load_valid&&load_ready; rw=1, PC_write=current address, instruction_in=load_word are registered in the same edge and held for exactly one cycle; rw=0 otherwise.
REQ-022 The load address starts at 0 on entry to LOAD and advances by ADDR_STEP per transfer, modulo 2^PC_SIZE.
REQ-023 A transfer whose advance would wrap the address to 0 without load_last sets overflow (sticky) and moves to DONE; that word is still written.
REQ-024 load_valid low in LOAD: no write, address held, and no timeout.
REQ-025 run_count clears on entry to RUN, increments once per RUN cycle, saturates at 16'hFFFF, and is held in DONE.
REQ-026 halt_req sampled high in RUN -> DONE on the next edge; halt_req is ignored in other states.
REQ-027 busy=1 in CLEAR, LOAD and RUN; done=1 only in DONE; start is ignored in CLEAR, LOAD and RUN.

Reset
REQ-028 Asserting reset mid-operation aborts immediately: state=IDLE, core_reset=1, mem_reset=0, rw=0, PC_write=0, instruction_in=0, load_ready=0, busy=0, done=0, overflow=0, run_count=0, address counter=0.
REQ-029 Instruction-memory contents are not cleared by reset; they are cleared only by CLEAR.

Configuration
REQ-030 Macro PROG_LOAD_CYCLE_LIMIT_EN:
- Defined: RUN -> DONE when run_count+1 == max_cycles.
- Defined, max_cycles=0: no limit.
- Undefined: max_cycles is ignored; only halt_req ends RUN.

Structure
REQ-031 Shared package riscv_ctrl_pkg holds the state enumeration and the run_count width constant (16).
REQ-032 Sub-module prog_addr_counter: load/reset, step ADDR_STEP, wrap flag output; everything else stays in prog_load_ctrl.

Verification
REQ-033 Reset, then start, then 3 words (0x00500093, 0x00a00113, 0x002081b3; last on word 3) -> mem_reset high exactly 2 cycles; writes at PC_write 0, 4, 8 with rw pulses; state ARMED.
REQ-034 load_valid toggled 1,0,0,1 in LOAD -> exactly 2 writes at addresses 0 and 4; no write in the gap cycles.
REQ-035 ARMED, start, halt_req asserted after 10 RUN cycles -> core_reset low for exactly 10 cycles; run_count=10; done=1.
REQ-036 PC_SIZE=4, 5 words without load_last -> 4th write at 12, overflow=1, DONE, 5th word not accepted.
REQ-037 With PROG_LOAD_CYCLE_LIMIT_EN, max_cycles=7 -> DONE after 7 RUN cycles, run_count=7; without the macro, RUN continues until halt_req.
REQ-038 reset asserted during LOAD mid-transfer -> next cycle all outputs at REQ-028 values; a new start reloads from address 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding and run counter width for the program loader
package riscv_ctrl_pkg;
  localparam int RUN_W = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, ARMED, RUN, DONE} state_t;
endpackage

// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if: valid/ready word stream feeding the program loader
interface prog_load_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_word;
  logic        load_last;
  modport master(output load_valid, load_word, load_last, input load_ready);
  modport slave(input load_valid, load_word, load_last, output load_ready);
endinterface

// File: rtl/prog_addr_counter.sv
// prog_addr_counter: load address counter stepping by ADDR_STEP with a wrap-ahead flag
module prog_addr_counter #(
  parameter int PC_SIZE   = 10,
  parameter int ADDR_STEP = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [PC_SIZE-1:0] addr,
  output logic               wrap
);
  logic [PC_SIZE:0] sum;
  assign sum  = {1'b0, addr} + (PC_SIZE+1)'(ADDR_STEP);
  assign wrap = sum[PC_SIZE];
  always_ff @(posedge clock or posedge reset)
    if (reset) addr <= '0;
    else if (clr) addr <= '0;
    else if (inc) addr <= sum[PC_SIZE-1:0];
endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: clears instruction memory, streams a program into it and runs the core.
// Optional run-cycle limit enabled by PROG_LOAD_CYCLE_LIMIT_EN.
module prog_load_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int PC_SIZE      = 10,
  parameter int ADDR_STEP    = 4,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  prog_load_ctrl_if.slave    bus,
  input  logic               start,
  input  logic               halt_req,
  input  logic [RUN_W-1:0]   max_cycles,
  output logic               core_reset,
  output logic               mem_reset,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [RUN_W-1:0]   run_count
);
  state_t             state, nxt;
  logic [7:0]         clr_cnt;
  logic [PC_SIZE-1:0] addr;
  logic               wrap, xfer, limit;
  assign xfer = bus.load_valid && bus.load_ready;
`ifdef PROG_LOAD_CYCLE_LIMIT_EN
  assign limit = (max_cycles != '0) && (run_count + RUN_W'(1) == max_cycles);
`else
  logic unused_max;
  assign unused_max = ^max_cycles;
  assign limit      = 1'b0;
`endif
  prog_addr_counter #(.PC_SIZE(PC_SIZE), .ADDR_STEP(ADDR_STEP)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (state == CLEAR),
    .inc  (xfer),
    .addr (addr),
    .wrap (wrap)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = (clr_cnt == 8'(CLEAR_CYCLES - 1)) ? LOAD : CLEAR;
      LOAD:    nxt = (xfer && bus.load_last) ? ARMED : (xfer && wrap) ? DONE : LOAD;
      ARMED:   nxt = start ? RUN : ARMED;
      RUN:     nxt = (halt_req || limit) ? DONE : RUN;
      DONE:    nxt = start ? CLEAR : DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state          <= IDLE;
      clr_cnt        <= '0;
      core_reset     <= 1'b1;
      mem_reset      <= 1'b0;
      rw             <= 1'b0;
      PC_write       <= '0;
      instruction_in <= '0;
      bus.load_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      run_count      <= '0;
    end else begin
      state          <= nxt;
      clr_cnt        <= (state == CLEAR) ? clr_cnt + 8'd1 : 8'd0;
      core_reset     <= nxt != RUN;
      mem_reset      <= nxt == CLEAR;
      bus.load_ready <= nxt == LOAD;
      busy           <= nxt inside {CLEAR, LOAD, RUN};
      done           <= nxt == DONE;
      rw             <= xfer;
      if (xfer) begin
        PC_write       <= addr;
        instruction_in <= bus.load_word;
      end
      if (xfer && !bus.load_last && wrap) overflow <= 1'b1;
      run_count <= (state == ARMED && nxt == RUN) ? '0 :
                   (state == RUN && run_count != '1) ? run_count + RUN_W'(1) : run_count;
    end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed and randomized checks of prog_load_ctrl against a behavioural model
module tb_prog_load_ctrl;
  import riscv_ctrl_pkg::*;
  localparam int PC   = 10;
  localparam int STEP = 4;
  logic clock = 0, reset, start, halt_req;
  logic [15:0] max_cycles;
  logic core_reset, mem_reset, rw, busy, done, overflow;
  logic [PC-1:0] PC_write;
  logic [31:0] instruction_in;
  logic [15:0] run_count;
  logic core_reset4, mem_reset4, rw4, busy4, done4, overflow4;
  logic [3:0] PC_write4;
  logic [31:0] instruction_in4;
  logic [15:0] run_count4;
  int total = 0, passed = 0, fails = 0;
  int mem_hi = 0, core_lo = 0;
  logic [31:0] wr_a[$], wr_d[$], wr4_a[$], wr4_d[$], prog[$];

  prog_load_ctrl_if bus();
  prog_load_ctrl_if bus4();

  prog_load_ctrl dut (
    .clock(clock), .reset(reset), .bus(bus), .start(start), .halt_req(halt_req),
    .max_cycles(max_cycles), .core_reset(core_reset), .mem_reset(mem_reset), .rw(rw),
    .PC_write(PC_write), .instruction_in(instruction_in), .busy(busy), .done(done),
    .overflow(overflow), .run_count(run_count)
  );

  prog_load_ctrl #(.PC_SIZE(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .start(start), .halt_req(halt_req),
    .max_cycles(max_cycles), .core_reset(core_reset4), .mem_reset(mem_reset4), .rw(rw4),
    .PC_write(PC_write4), .instruction_in(instruction_in4), .busy(busy4), .done(done4),
    .overflow(overflow4), .run_count(run_count4)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rw) begin
      wr_a.push_back(32'(PC_write));
      wr_d.push_back(instruction_in);
    end
    if (rw4) begin
      wr4_a.push_back(32'(PC_write4));
      wr4_d.push_back(instruction_in4);
    end
    if (mem_reset) mem_hi++;
    if (!core_reset) core_lo++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.load_ready; i++) tick();
    check("load_ready_wait", 32'(bus.load_ready), 1);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 1);
    check({tag, "_mem_reset"}, 32'(mem_reset), 0);
    check({tag, "_rw"}, 32'(rw), 0);
    check({tag, "_pc"}, 32'(PC_write), 0);
    check({tag, "_instr"}, instruction_in, 0);
    check({tag, "_ready"}, 32'(bus.load_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_run_count"}, 32'(run_count), 0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  task automatic load_prog(int n, int max_gap);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 0;
      repeat ($urandom_range(0, max_gap)) tick();
      bus.load_valid = 1;
      bus.load_word  = prog[i];
      bus.load_last  = (i == n - 1);
      tick();
    end
    bus.load_valid = 0;
    bus.load_last  = 0;
    tick();
  endtask

  task automatic check_writes(string tag, int n);
    check({tag, "_nwrites"}, 32'(wr_a.size()), 32'(n));
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      check({tag, "_addr"}, wr_a[i], (i * STEP) % (1 << PC));
      check({tag, "_data"}, wr_d[i], prog[i]);
    end
  endtask

  task automatic run_for(string tag, int r);
    core_lo = 0;
    pulse_start();
    repeat (r - 1) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    check({tag, "_core_low_cycles"}, 32'(core_lo), 32'(r));
    check({tag, "_run_count"}, 32'(run_count), 32'(r));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int cyc, n, r;
    logic [15:0] held;
    bus.load_valid = 0; bus.load_word = 0; bus.load_last = 0;
    bus4.load_valid = 0; bus4.load_word = 0; bus4.load_last = 0;
    start = 0; halt_req = 0; max_cycles = 0;
    do_reset();
    check_reset_vals("reset");

    // basic three-word load
    wr_a.delete(); wr_d.delete();
    prog = '{32'h00500093, 32'h00a00113, 32'h002081b3};
    mem_hi = 0;
    pulse_start();
    check("clear_state", 32'(dut.state), 32'(CLEAR));
    check("clear_busy", 32'(busy), 1);
    wait_ready();
    check("clear_cycles", 32'(mem_hi), 2);
    load_prog(3, 0);
    check_writes("load3", 3);
    check("load3_state", 32'(dut.state), 32'(ARMED));
    check("load3_mem_reset_total", 32'(mem_hi), 2);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("armed_ignores_halt", 32'(dut.state), 32'(ARMED));
    run_for("run10", 10);
    held = run_count;
    repeat (2) tick();
    check("done_holds_count", 32'(run_count), 32'(held));

    // cycle limit
    wr_a.delete(); wr_d.delete();
    prog = '{32'h12345678};
    pulse_start();
    wait_ready();
    load_prog(1, 0);
    check("limit_armed", 32'(dut.state), 32'(ARMED));
    max_cycles = 7;
    core_lo = 0;
    pulse_start();
    cyc = 0;
    while (cyc < 30 && !done) begin
      tick();
      cyc++;
    end
`ifdef PROG_LOAD_CYCLE_LIMIT_EN
    check("limit_cycles", 32'(cyc), 7);
    check("limit_run_count", 32'(run_count), 7);
    check("limit_done", 32'(done), 1);
    check("limit_core_low", 32'(core_lo), 7);
`else
    check("nolimit_cycles", 32'(cyc), 30);
    check("nolimit_busy", 32'(busy), 1);
    check("nolimit_run_count", 32'(run_count), 30);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("nolimit_halt_done", 32'(done), 1);
    check("nolimit_halt_count", 32'(run_count), 31);
`endif
    max_cycles = 0;

    // valid gaps
    do_reset();
    wr_a.delete(); wr_d.delete();
    prog = '{32'hdeadbeef, 32'hcafef00d};
    pulse_start();
    wait_ready();
    bus.load_valid = 1; bus.load_word = prog[0]; bus.load_last = 0;
    tick();
    check("gap_w0_rw", 32'(rw), 1);
    bus.load_valid = 0;
    tick();
    check("gap1_rw", 32'(rw), 0);
    tick();
    check("gap2_rw", 32'(rw), 0);
    check("gap_still_load", 32'(dut.state), 32'(LOAD));
    bus.load_valid = 1; bus.load_word = prog[1]; bus.load_last = 1;
    tick();
    check("gap_w1_rw", 32'(rw), 1);
    bus.load_valid = 0; bus.load_last = 0;
    tick();
    check_writes("gap", 2);
    check("gap_state", 32'(dut.state), 32'(ARMED));

    // address wrap on a 4-bit PC
    do_reset();
    wr4_a.delete(); wr4_d.delete();
    pulse_start();
    for (int i = 0; i < 20 && !bus4.load_ready; i++) tick();
    check("ovf_ready_wait", 32'(bus4.load_ready), 1);
    for (int i = 0; i < 5; i++) begin
      bus4.load_valid = 1; bus4.load_word = 32'(100 + i); bus4.load_last = 0;
      tick();
    end
    bus4.load_valid = 0;
    tick();
    check("ovf_nwrites", 32'(wr4_a.size()), 4);
    for (int i = 0; i < 4 && i < wr4_a.size(); i++) begin
      check("ovf_addr", wr4_a[i], 32'(i * STEP));
      check("ovf_data", wr4_d[i], 32'(100 + i));
    end
    check("ovf_flag", 32'(overflow4), 1);
    check("ovf_done", 32'(done4), 1);
    check("ovf_ready_low", 32'(bus4.load_ready), 0);
    check("ovf_state", 32'(dut4.state), 32'(DONE));

    // reset in the middle of a transfer
    do_reset();
    pulse_start();
    wait_ready();
    bus.load_valid = 1; bus.load_word = 32'h0badf00d; bus.load_last = 0;
    tick();
    check("midreset_rw_before", 32'(rw), 1);
    reset = 1;
    #1;
    check_reset_vals("midreset_async");
    check("midreset_addr", 32'(dut.u_cnt.addr), 0);
    tick();
    check_reset_vals("midreset_next");
    reset = 0;
    bus.load_valid = 0;
    tick();
    wr_a.delete(); wr_d.delete();
    prog = '{32'h11111111, 32'h22222222};
    pulse_start();
    wait_ready();
    load_prog(2, 1);
    check_writes("reload", 2);

    // randomized programs and run lengths
    for (int k = 0; k < 4; k++) begin
      do_reset();
      wr_a.delete(); wr_d.delete(); prog.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      pulse_start();
      wait_ready();
      load_prog(n, 2);
      check_writes("rand_load", n);
      check("rand_armed", 32'(dut.state), 32'(ARMED));
      r = $urandom_range(1, 20);
      run_for("rand_run", r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
